// File: rtl/delay_tap_calibrator.sv
// -----------------------------------------------------------------------------
// delay_tap_calibrator
//
// Calibrates an 8-tap programmable delay line. On start it sweeps taps 0..7.
// For each tap it holds dl_in low for SETTLE cycles with the tap applied, then
// launches a one-cycle rising edge. It samples dl_out at the edge that ends the
// launch cycle, and repeats this NTRIALS times. A tap qualifies when at least
// THRESH launches arrive within one clock period. The highest qualifying tap is
// then held on dl_sel. While idle, dl_sel follows an optional manual setting.
//
// Parameters
//   NTRIALS : launch/sample trials per tap (1..15)
//   THRESH  : minimum pass count for a tap to qualify (1..NTRIALS)
//   SETTLE  : low cycles with the tap applied before each launch (1..15)
//
// Ports
//   clk       : clock
//   rst       : synchronous reset, active-high
//   start     : one-cycle calibration request, honoured in IDLE and DONE only
//   man_en    : 1 = dl_sel follows man_sel while in IDLE
//   man_sel   : manual tap
//   dl_in     : registered launch signal to the delay-line input
//   dl_out    : delay-line output, sampled directly
//   dl_sel    : registered tap select (bit0 -> s0, bit1 -> s1, bit2 -> s2)
//   busy      : high in SETTLE, LAUNCH and EVAL
//   done      : high in DONE
//   fail      : valid with done; 1 = no tap qualified
//   result    : selected tap, valid with done (0 when fail)
//   state_dbg : current FSM state encoding
//
// Handshake: start is a request pulse. It is accepted only when busy is low,
// and a pulse while busy is dropped. Acceptance clears done, fail and result in
// the following cycle. done then stays high, with fail and result stable, until
// the next accepted start or reset.
// -----------------------------------------------------------------------------
module delay_tap_calibrator #(
  parameter int NTRIALS = 8,
  parameter int THRESH  = 8,
  parameter int SETTLE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       man_en,
  input  logic [2:0] man_sel,
  output logic       dl_in,
  input  logic       dl_out,
  output logic [2:0] dl_sel,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [2:0] result,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_LAUNCH = 3'd2,
    S_EVAL   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] NTRIALS_C   = 4'(NTRIALS);
  localparam logic [3:0] THRESH_C    = 4'(THRESH);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [3:0] settle_cnt, settle_cnt_n;
  logic [3:0] trial, trial_n;
  logic [3:0] pass_cnt, pass_cnt_n;
  logic [2:0] tap, tap_n;
  logic [2:0] best, best_n;
  logic       found, found_n;
  logic       dl_in_n;
  logic [2:0] dl_sel_n;

  // Next-state, counter updates and next register values for the outputs.
  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    trial_n      = trial;
    pass_cnt_n   = pass_cnt;
    tap_n        = tap;
    best_n       = best;
    found_n      = found;
    dl_in_n      = 1'b0;
    dl_sel_n     = 3'd0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n      = S_SETTLE;
          settle_cnt_n = 4'd0;
          trial_n      = 4'd0;
          pass_cnt_n   = 4'd0;
          tap_n        = 3'd0;
          best_n       = 3'd0;
          found_n      = 1'b0;
        end
      end

      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_n      = S_LAUNCH;
          settle_cnt_n = 4'd0;
        end else begin
          settle_cnt_n = settle_cnt + 4'd1;
        end
      end

      S_LAUNCH: begin
        // dl_in is high during this cycle. A launch passes if it has already
        // reached dl_out by the edge that ends the cycle.
        if (dl_out && (pass_cnt != 4'd15)) begin
          pass_cnt_n = pass_cnt + 4'd1;
        end
        trial_n = trial + 4'd1;
        if (trial_n == NTRIALS_C) begin
          state_n = S_EVAL;
        end else begin
          state_n = S_SETTLE;
        end
      end

      S_EVAL: begin
        // The sweep is ascending, so a later qualifying tap overwrites an
        // earlier one. Non-monotonic lines are accepted as-is.
        if (pass_cnt >= THRESH_C) begin
          best_n  = tap;
          found_n = 1'b1;
        end
        pass_cnt_n = 4'd0;
        trial_n    = 4'd0;
        if (tap == 3'd7) begin
          state_n = S_DONE;
        end else begin
          tap_n   = tap + 3'd1;
          state_n = S_SETTLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Both line controls are registered from the next state. dl_in is high
    // only in LAUNCH. The tap changes only when entering SETTLE, and dl_in is
    // already low at that point.
    dl_in_n = (state_n == S_LAUNCH);
    case (state_n)
      S_IDLE:  dl_sel_n = man_en ? man_sel : 3'd0;
      S_DONE:  dl_sel_n = found_n ? best_n : 3'd0;
      default: dl_sel_n = tap_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= 4'd0;
      trial      <= 4'd0;
      pass_cnt   <= 4'd0;
      tap        <= 3'd0;
      best       <= 3'd0;
      found      <= 1'b0;
      dl_in      <= 1'b0;
      dl_sel     <= 3'd0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
      trial      <= trial_n;
      pass_cnt   <= pass_cnt_n;
      tap        <= tap_n;
      best       <= best_n;
      found      <= found_n;
      dl_in      <= dl_in_n;
      dl_sel     <= dl_sel_n;
    end
  end

  // Status outputs decode the state register directly, so they are glitch-free
  // and are zero in reset.
  assign busy      = (state == S_SETTLE) || (state == S_LAUNCH) || (state == S_EVAL);
  assign done      = (state == S_DONE);
  assign fail      = done && !found;
  assign result    = (done && found) ? best : 3'd0;
  assign state_dbg = state;

endmodule

// File: tb/tb_delay_tap_calibrator.sv
// -----------------------------------------------------------------------------
// tb_delay_tap_calibrator
//
// Two instances share clk, rst, start and the manual inputs: u_dut_a uses the
// default THRESH=8 and u_dut_b uses THRESH=7. Each instance drives its own
// behavioural delay-line model, selected by `mode`.
// Cycle numbering: cycle 1 is the first cycle after the edge that samples
// start. The first SETTLE cycle is cycle 1, busy covers cycles 1..200, and done
// first appears in cycle 201.
// -----------------------------------------------------------------------------
module tb_delay_tap_calibrator;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start;
  logic       man_en;
  logic [2:0] man_sel;

  logic       dl_in_a, dl_out_a, busy_a, done_a, fail_a;
  logic [2:0] dl_sel_a, result_a, state_a;
  logic       dl_in_b, dl_out_b, busy_b, done_b, fail_b;
  logic [2:0] dl_sel_b, result_b, state_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int mode = 0;

  logic din_d_a = 1'b0;
  logic din_d_b = 1'b0;
  int   cnt6_a = 0;
  int   cnt6_b = 0;

  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];

  delay_tap_calibrator u_dut_a (
    .clk(clk), .rst(rst), .start(start), .man_en(man_en), .man_sel(man_sel),
    .dl_in(dl_in_a), .dl_out(dl_out_a), .dl_sel(dl_sel_a), .busy(busy_a),
    .done(done_a), .fail(fail_a), .result(result_a), .state_dbg(state_a)
  );

  delay_tap_calibrator #(.THRESH(7)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .man_en(man_en), .man_sel(man_sel),
    .dl_in(dl_in_b), .dl_out(dl_out_b), .dl_sel(dl_sel_b), .busy(busy_b),
    .done(done_b), .fail(fail_b), .result(result_b), .state_dbg(state_b)
  );

  // ---------------- delay-line model ----------------
  // A tap that fits passes dl_in straight through. A tap that is too slow
  // shows dl_in one cycle late. In mode 2, tap 6 misses only its first launch.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    din_d_a <= dl_in_a;
    din_d_b <= dl_in_b;
    if (start) begin
      cnt6_a <= 0;
      cnt6_b <= 0;
    end else begin
      if (dl_in_a && dl_sel_a == 3'd6) cnt6_a <= cnt6_a + 1;
      if (dl_in_b && dl_sel_b == 3'd6) cnt6_b <= cnt6_b + 1;
    end
  end

  function automatic logic line_model(input int m, input logic [2:0] sel,
                                      input logic din, input logic dind, input int c6);
    logic ok;
    case (m)
      0:       ok = (sel <= 3'd4);
      1:       ok = 1'b0;
      2: begin
        if (sel == 3'd6) return din && (c6 != 0);
        ok = (sel <= 3'd5);
      end
      3:       ok = (sel == 3'd0) || (sel == 3'd1) || (sel == 3'd3);
      default: ok = 1'b1;
    endcase
    return ok ? din : dind;
  endfunction

  assign dl_out_a = line_model(mode, dl_sel_a, dl_in_a, din_d_a, cnt6_a);
  assign dl_out_b = line_model(mode, dl_sel_b, dl_in_b, din_d_b, cnt6_b);

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int lat, input int f, input int r, input int s);
    return {9'(lat), 1'(f), 3'(r), 3'(s)};
  endfunction

  // ---------------- scoreboard monitors ----------------
  initial begin : mon_a
    logic prev;
    logic [W-1:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_a && !prev) begin
        if (exp_qa.size() == 0) check("a_unexpected_done", 1, 0);
        else begin
          e = exp_qa.pop_front();
          check("a_done_lat_fail_res_sel",
                int'(pack(cyc - start_cyc, fail_a, result_a, dl_sel_a)), int'(e));
        end
      end
      prev = done_a;
    end
  end

  initial begin : mon_b
    logic prev;
    logic [W-1:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_b && !prev) begin
        if (exp_qb.size() == 0) check("b_unexpected_done", 1, 0);
        else begin
          e = exp_qb.pop_front();
          check("b_done_lat_fail_res_sel",
                int'(pack(cyc - start_cyc, fail_b, result_b, dl_sel_b)), int'(e));
        end
      end
      prev = done_b;
    end
  end

  // ---------------- driver ----------------
  // Pulses start and pushes the expected outcomes. While the sweep runs it
  // checks the dl_in, dl_sel and busy waveform of instance a. extra_at > 0
  // pulses start again in that cycle. rst_at > 0 aborts the sweep with a reset.
  task automatic run_sweep(input int m, input int ra, input int fa, input int rb,
                           input int fb, input int extra_at, input int rst_at);
    int busy_cnt, din_cnt, din_bad, sel_bad, p;
    logic exp_din;
    busy_cnt = 0; din_cnt = 0; din_bad = 0; sel_bad = 0;
    @(negedge clk);
    mode      = m;
    start     = 1'b1;
    start_cyc = cyc;
    if (rst_at == 0) begin
      exp_qa.push_back(pack(201, fa, ra, fa ? 0 : ra));
      exp_qb.push_back(pack(201, fb, rb, fb ? 0 : rb));
    end
    for (int c = 1; c <= 201; c++) begin
      @(negedge clk);
      start = (c == extra_at);
      if (c <= 200) begin
        p       = (c - 1) % 25;
        exp_din = (p < 24) && (p % 3 == 2);
        if (dl_in_a !== exp_din) din_bad++;
        if (dl_in_a) din_cnt++;
        if (int'(dl_sel_a) != (c - 1) / 25) sel_bad++;
        if (busy_a) busy_cnt++;
      end else begin
        check("busy_low_in_cycle_201", busy_a, 0);
        check("done_high_in_cycle_201", done_a, 1);
      end
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", int'({dl_in_a, dl_sel_a, busy_a, done_a, fail_a, result_a}), 0);
        check("abort_state_idle", state_a, 0);
        check("abort_b_busy", busy_b, 0);
        return;
      end
    end
    start = 1'b0;
    check("dl_in_pulse_count", din_cnt, 64);
    check("dl_in_pattern_errs", din_bad, 0);
    check("dl_sel_step_errs", sel_bad, 0);
    check("busy_cycles", busy_cnt, 200);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; man_en = 1'b0; man_sel = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", int'({dl_in_a, dl_sel_a, busy_a, done_a, fail_a, result_a}), 0);
    check("reset_state", state_a, 0);

    // manual select in IDLE, one cycle of latency
    man_en = 1'b1; man_sel = 3'd5;
    #1 check("man_sel_not_yet", dl_sel_a, 0);
    @(negedge clk);
    check("man_sel_5", dl_sel_a, 5);
    check("man_busy", busy_a, 0);
    check("man_done", done_a, 0);
    man_en = 1'b0;
    @(negedge clk);
    check("man_off_sel_0", dl_sel_a, 0);

    // taps 0..4 fit, 5..7 too slow
    run_sweep(0, 4, 0, 4, 0, 0, 0);
    check("done_fail_0", fail_a, 0);

    // manual inputs ignored in DONE
    man_en = 1'b1; man_sel = 3'd2;
    repeat (2) @(negedge clk);
    check("done_ignores_man", dl_sel_a, 4);
    check("done_holds", done_a, 1);
    man_en = 1'b0;

    run_sweep(1, 0, 1, 0, 1, 0, 0);   // nothing qualifies
    run_sweep(2, 5, 0, 6, 0, 0, 0);   // tap 6 passes 7 of 8
    run_sweep(3, 3, 0, 3, 0, 0, 0);   // non-monotonic: 0,1,3 pass
    run_sweep(4, 7, 0, 7, 0, 0, 0);   // every tap fits
    run_sweep(0, 4, 0, 4, 0, 50, 0);  // extra start while busy is ignored
    run_sweep(0, 4, 0, 4, 0, 0, 120); // reset mid-sweep

    repeat (5) @(negedge clk);
    check("a_queue_empty", exp_qa.size(), 0);
    check("b_queue_empty", exp_qb.size(), 0);
    check("idle_after_abort", state_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
